// File: rtl/instruction_fetch_unit.sv
// IF stage: PC, req/ready fetch, IF/ID register and redirect on branch/jump. Latency 1 cycle from transfer to IF/ID.
// Stalls park a completed fetch in a one-word skid buffer; redirects mid-request keep the address stable via SQUASH.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Jump_Signal,
  output logic [31:0] Imem_Addr,
  output logic        Imem_Req,
  input  logic [31:0] Imem_Rdata,
  input  logic        Imem_Ready,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC_Plus4,
  output logic        IF_ID_Valid,
  output logic [5:0]  Instruction_Op_Code
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [31:0] RST_PC = RESET_PC & ~32'h3;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] addr, addr_n;
  logic        req, req_n;
  logic [31:0] skid, skid_n;
  logic        skid_v, skid_v_n;
  logic [31:0] instr, instr_n;
  logic [31:0] pc4, pc4_n;
  logic        valid, valid_n;

  logic        xfer;
  logic        jump_q;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] target;

  assign xfer       = req && Imem_Ready;
  assign jump_q     = Jump_Signal && valid;
  assign redirect   = Branch_Taken || jump_q;
  assign pc_plus4   = pc + 32'd4;
  assign branch_tgt = Branch_Target & ~32'h3;
  assign jump_tgt   = {pc4[31:28], instr[25:0], 2'b00};
  assign target     = Branch_Taken ? branch_tgt : jump_tgt;

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    skid_n   = skid;
    skid_v_n = skid_v;
    instr_n  = instr;
    pc4_n    = pc4;
    valid_n  = valid;
    if (redirect) begin
      instr_n  = NOP_WORD;
      valid_n  = 1'b0;
      skid_v_n = 1'b0;
      pc_n     = target;
      // An outstanding request must keep its address until memory accepts it.
      state_n  = (state != HOLD && req && !xfer) ? SQUASH : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (xfer) begin
            pc_n = pc_plus4;
            if (!Stall) begin
              instr_n = Imem_Rdata;
              pc4_n   = pc_plus4;
              valid_n = 1'b1;
            end else begin
              skid_n   = Imem_Rdata;
              skid_v_n = 1'b1;
              state_n  = HOLD;
            end
          end else if (!Stall) begin
            instr_n = NOP_WORD;
            valid_n = 1'b0;
          end
        end
        HOLD: begin
          if (!Stall) begin
            instr_n  = skid;
            pc4_n    = pc;
            valid_n  = 1'b1;
            skid_v_n = 1'b0;
            state_n  = FETCH;
          end
        end
        SQUASH: begin
          if (xfer) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
    addr_n = (state_n == SQUASH) ? addr : pc_n;
    req_n  = (state_n != HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= RST_PC;
      addr   <= RST_PC;
      req    <= 1'b0;
      skid   <= 32'h0;
      skid_v <= 1'b0;
      instr  <= NOP_WORD;
      pc4    <= 32'h0;
      valid  <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      addr   <= addr_n;
      req    <= req_n;
      skid   <= skid_n;
      skid_v <= skid_v_n;
      instr  <= instr_n;
      pc4    <= pc4_n;
      valid  <= valid_n;
    end
  end

  assign Imem_Addr           = addr;
  assign Imem_Req            = req;
  assign IF_ID_Instruction   = instr;
  assign IF_ID_PC_Plus4      = pc4;
  assign IF_ID_Valid         = valid;
  assign Instruction_Op_Code = instr[31:26];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table for streaming/stall/jump, hand sequences for squash, priority, wrap and reset.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Jump_Signal;
  logic [31:0] Imem_Addr;
  logic        Imem_Req;
  logic [31:0] Imem_Rdata;
  logic        Imem_Ready;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PC_Plus4;
  logic        IF_ID_Valid;
  logic [5:0]  Instruction_Op_Code;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .Stall               (Stall),
    .Branch_Taken        (Branch_Taken),
    .Branch_Target       (Branch_Target),
    .Jump_Signal         (Jump_Signal),
    .Imem_Addr           (Imem_Addr),
    .Imem_Req            (Imem_Req),
    .Imem_Rdata          (Imem_Rdata),
    .Imem_Ready          (Imem_Ready),
    .IF_ID_Instruction   (IF_ID_Instruction),
    .IF_ID_PC_Plus4      (IF_ID_PC_Plus4),
    .IF_ID_Valid         (IF_ID_Valid),
    .Instruction_Op_Code (Instruction_Op_Code)
  );

  always #5 clk = ~clk;

  // Memory model: address 0x10 holds "j 0x100", everything else is addr | A000_0000.
  assign Imem_Rdata = (Imem_Addr == 32'h10) ? 32'h0800_0040 : (Imem_Addr | 32'hA000_0000);

  typedef struct {
    logic        stall;
    logic        bt;
    logic [31:0] btgt;
    logic        jump;
    logic        ready;
    logic [31:0] e_addr;
    logic        e_req;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        chk_pc4;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(logic stall, logic jump, logic [31:0] e_addr, logic e_req,
                              logic [31:0] e_instr, logic [31:0] e_pc4, logic e_valid, logic chk_pc4);
    vec_t v;
    v.stall = stall; v.bt = 1'b0; v.btgt = 32'h0; v.jump = jump; v.ready = 1'b1;
    v.e_addr = e_addr; v.e_req = e_req; v.e_instr = e_instr; v.e_pc4 = e_pc4;
    v.e_valid = e_valid; v.chk_pc4 = chk_pc4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic stall, input logic bt, input logic [31:0] btgt,
                       input logic jump, input logic ready);
    Stall = stall; Branch_Taken = bt; Branch_Target = btgt; Jump_Signal = jump; Imem_Ready = ready;
  endtask

  task automatic expect_out(input string name, input logic [31:0] addr, input logic req,
                            input logic [31:0] instr, input logic valid);
    chk({name, ".addr"},  Imem_Addr, addr);
    chk({name, ".req"},   {31'h0, Imem_Req}, {31'h0, req});
    chk({name, ".instr"}, IF_ID_Instruction, instr);
    chk({name, ".op"},    {26'h0, Instruction_Op_Code}, {26'h0, instr[31:26]});
    chk({name, ".valid"}, {31'h0, IF_ID_Valid}, {31'h0, valid});
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 32'h000, 1, 32'h0000_0000, 32'h000, 0, 1);
    tbl[1]  = mk(0, 0, 32'h004, 1, 32'hA000_0000, 32'h004, 1, 1);
    tbl[2]  = mk(0, 0, 32'h008, 1, 32'hA000_0004, 32'h008, 1, 1);
    tbl[3]  = mk(1, 0, 32'h00C, 0, 32'hA000_0004, 32'h008, 1, 1);
    tbl[4]  = mk(1, 0, 32'h00C, 0, 32'hA000_0004, 32'h008, 1, 1);
    tbl[5]  = mk(1, 0, 32'h00C, 0, 32'hA000_0004, 32'h008, 1, 1);
    tbl[6]  = mk(0, 0, 32'h00C, 1, 32'hA000_0008, 32'h00C, 1, 1);
    tbl[7]  = mk(0, 0, 32'h010, 1, 32'hA000_000C, 32'h010, 1, 1);
    tbl[8]  = mk(0, 0, 32'h014, 1, 32'h0800_0040, 32'h014, 1, 1);
    tbl[9]  = mk(0, 1, 32'h100, 1, 32'h0000_0000, 32'h000, 0, 0);
    tbl[10] = mk(0, 0, 32'h104, 1, 32'hA000_0100, 32'h104, 1, 1);
    tbl[11] = mk(0, 0, 32'h108, 1, 32'hA000_0104, 32'h108, 1, 1);

    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 1);
    step();
    step();
    expect_out("reset", 32'h0, 0, 32'h0, 0);
    chk("reset.pc4", IF_ID_PC_Plus4, 32'h0);

    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].stall, tbl[i].bt, tbl[i].btgt, tbl[i].jump, tbl[i].ready);
      step();
      expect_out($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_req, tbl[i].e_instr, tbl[i].e_valid);
      if (tbl[i].chk_pc4) chk($sformatf("vec%0d.pc4", i), IF_ID_PC_Plus4, tbl[i].e_pc4);
    end

    // Branch to 0x30, then a second branch while the 0x30 request is stuck.
    drive(0, 1, 32'h30, 0, 1);   step(); expect_out("br30", 32'h30, 1, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 0);    step(); expect_out("wait30", 32'h30, 1, 32'h0, 0);
    drive(0, 1, 32'h200, 0, 0);  step(); expect_out("sq_enter", 32'h30, 1, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 0);    step(); expect_out("sq_wait", 32'h30, 1, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 1);    step(); expect_out("sq_drop", 32'h200, 1, 32'h0, 0);
    step(); expect_out("sq_after", 32'h204, 1, 32'hA000_0200, 1);
    chk("sq_after.pc4", IF_ID_PC_Plus4, 32'h204);

    // Branch beats a simultaneous qualified jump.
    drive(0, 1, 32'h10, 0, 1);   step(); expect_out("br10", 32'h10, 1, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 1);    step(); expect_out("ld_jmp", 32'h14, 1, 32'h0800_0040, 1);
    drive(0, 1, 32'h200, 1, 1);  step(); expect_out("prio", 32'h200, 1, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 1);    step(); expect_out("prio_after", 32'h204, 1, 32'hA000_0200, 1);

    // Branch flushes even while stalled.
    drive(1, 1, 32'h40, 0, 1);   step(); expect_out("br_stall", 32'h40, 1, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 1);    step(); expect_out("br_stall_after", 32'h44, 1, 32'hA000_0040, 1);

    // PC wrap-around.
    drive(0, 1, 32'hFFFF_FFFC, 0, 1); step(); expect_out("br_top", 32'hFFFF_FFFC, 1, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 1);    step(); expect_out("wrap", 32'h0, 1, 32'hFFFF_FFFC, 1);
    chk("wrap.pc4", IF_ID_PC_Plus4, 32'h0);

    // Reset asserted while a stalled word sits in the skid buffer.
    drive(1, 0, 32'h0, 0, 1);    step(); expect_out("stall_hold", 32'h4, 0, 32'hFFFF_FFFC, 1);
    reset = 1'b1;                step(); expect_out("mid_reset", 32'h0, 0, 32'h0, 0);
    chk("mid_reset.pc4", IF_ID_PC_Plus4, 32'h0);
    reset = 1'b0;
    drive(0, 0, 32'h0, 0, 1);    step(); expect_out("rel1", 32'h0, 1, 32'h0, 0);
    step(); expect_out("rel2", 32'h4, 1, 32'hA000_0000, 1);
    chk("rel2.pc4", IF_ID_PC_Plus4, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
